// File: rtl/operand_loader_pkg.sv
// ------------------------------------------------------------------
// operand_loader_pkg : state encodings and default widths for operand_loader
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

package operand_loader_pkg;
  localparam int NB_DATA_DEF = 4;
  localparam int NB_OP_DEF   = 6;

  typedef enum logic [1:0] {
    S_A    = 2'b00,
    S_B    = 2'b01,
    S_OP   = 2'b10,
    S_DONE = 2'b11
  } state_t;
endpackage

`default_nettype wire

// File: rtl/operand_loader_btn_debounce.sv
// ------------------------------------------------------------------
// btn_debounce : 2-flop synchronizer, counter debounce, rising-edge pulse
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic press
);
  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= 2'b00;
      stable <= 1'b0;
      cnt    <= '0;
      press  <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      press <= 1'b0;
      if (sync[1] == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        // DEB_CYCLES-th consecutive differing sample: accept the new level
        stable <= sync[1];
        cnt    <= '0;
        press  <= sync[1];
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end
endmodule

`default_nettype wire

// File: rtl/operand_loader.sv
// ------------------------------------------------------------------
// operand_loader : loads ALU operands A, B and opcode from switches via buttons
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module operand_loader
  import operand_loader_pkg::*;
#(
  parameter int NB_DATA    = NB_DATA_DEF,
  parameter int NB_OP      = NB_OP_DEF,
  parameter int NB_SW      = 8,
  parameter int DEB_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               i_rst,
  input  logic [NB_SW-1:0]   i_sw,
  input  logic               i_btn_a,
  input  logic               i_btn_b,
  input  logic               i_btn_op,
  output logic [NB_DATA-1:0] o_datoA,
  output logic [NB_DATA-1:0] o_datoB,
  output logic [NB_OP-1:0]   o_operation,
  output logic               o_valid,
  output logic               o_ready,
  output logic [1:0]         o_state
);
  logic [2:0] btn_raw;
  logic [2:0] press;
  state_t     state;
  state_t     next_state;
  logic       load_a;
  logic       load_b;
  logic       load_op;
  logic       unused_sw;

  assign btn_raw   = {i_btn_op, i_btn_b, i_btn_a};
  assign unused_sw = ^i_sw;

  for (genvar i = 0; i < 3; i++) begin : g_btn
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (i_rst),
      .btn   (btn_raw[i]),
      .press (press[i])
    );
  end

  always_ff @(posedge clk) begin
    if (i_rst) state <= S_A;
    else       state <= next_state;
  end

  // Only the press matching the current state acts; the rest are dropped
  always_comb begin
    next_state = state;
    load_a     = 1'b0;
    load_b     = 1'b0;
    load_op    = 1'b0;
    case (state)
      S_A:    if (press[0]) begin load_a  = 1'b1; next_state = S_B;    end
      S_B:    if (press[1]) begin load_b  = 1'b1; next_state = S_OP;   end
      S_OP:   if (press[2]) begin load_op = 1'b1; next_state = S_DONE; end
      S_DONE: if (press[0]) begin load_a  = 1'b1; next_state = S_B;    end
      default: next_state = S_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      o_datoA     <= '0;
      o_datoB     <= '0;
      o_operation <= '0;
      o_valid     <= 1'b0;
      o_ready     <= 1'b0;
    end else begin
      if (load_a)  o_datoA     <= i_sw[NB_DATA-1:0];
      if (load_b)  o_datoB     <= i_sw[NB_DATA-1:0];
      if (load_op) o_operation <= i_sw[NB_OP-1:0];
      o_valid <= load_op;
      o_ready <= (next_state == S_DONE);
    end
  end

  assign o_state = state;
endmodule

`default_nettype wire

// File: tb/tb_operand_loader.sv
// ------------------------------------------------------------------
// tb_operand_loader : directed + randomized checks of operand_loader
// Revision: 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_operand_loader;
  localparam int NB_DATA = 4;
  localparam int NB_OP   = 6;
  localparam int NB_SW   = 8;
  localparam int DEB     = 4;

  logic               clk = 1'b0;
  logic               i_rst = 1'b1;
  logic [NB_SW-1:0]   i_sw = '0;
  logic               i_btn_a = 1'b0;
  logic               i_btn_b = 1'b0;
  logic               i_btn_op = 1'b0;
  logic [NB_DATA-1:0] o_datoA;
  logic [NB_DATA-1:0] o_datoB;
  logic [NB_OP-1:0]   o_operation;
  logic               o_valid;
  logic               o_ready;
  logic [1:0]         o_state;

  always #5 clk = ~clk;

  operand_loader #(
    .NB_DATA(NB_DATA), .NB_OP(NB_OP), .NB_SW(NB_SW), .DEB_CYCLES(DEB)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_sw(i_sw),
    .i_btn_a(i_btn_a), .i_btn_b(i_btn_b), .i_btn_op(i_btn_op),
    .o_datoA(o_datoA), .o_datoB(o_datoB), .o_operation(o_operation),
    .o_valid(o_valid), .o_ready(o_ready), .o_state(o_state)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference: which field is loaded next (0=A,1=B,2=OP,3=complete) and values
  int         m_stage;
  logic [3:0] m_a;
  logic [3:0] m_b;
  logic [5:0] m_op;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input bit valid_exp);
    check({tag, ".state"}, 32'(o_state), 32'(m_stage));
    check({tag, ".A"},     32'(o_datoA), 32'(m_a));
    check({tag, ".B"},     32'(o_datoB), 32'(m_b));
    check({tag, ".OP"},    32'(o_operation), 32'(m_op));
    check({tag, ".valid"}, 32'(o_valid), 32'(valid_exp));
    check({tag, ".ready"}, 32'(o_ready), 32'(m_stage == 3));
  endtask

  task automatic model_reset();
    m_stage = 0; m_a = '0; m_b = '0; m_op = '0;
  endtask

  // After completion the sequence restarts at A; only the awaited button counts
  task automatic model_press(input logic [2:0] mask, input logic [7:0] sw, output bit valid_exp);
    int want;
    valid_exp = 1'b0;
    want = (m_stage == 3) ? 0 : m_stage;
    if (mask[want]) begin
      case (want)
        0: m_a = sw[3:0];
        1: m_b = sw[3:0];
        default: begin m_op = sw[5:0]; valid_exp = 1'b1; end
      endcase
      m_stage = (want == 2) ? 3 : want + 1;
    end
  endtask

  task automatic set_btns(input logic [2:0] mask);
    i_btn_a = mask[0]; i_btn_b = mask[1]; i_btn_op = mask[2];
  endtask

  // Steady rise -> pulse DEB+2 cycles later -> registered outputs one edge after that
  task automatic expect_load(input string tag, input logic [2:0] mask, input logic [7:0] sw);
    bit v;
    repeat (DEB + 2) tick();
    check_all({tag, ".pre"}, 1'b0);
    model_press(mask, sw, v);
    tick();
    check_all({tag, ".load"}, v);
    tick();
    check_all({tag, ".after"}, 1'b0);
  endtask

  task automatic do_press(input string tag, input logic [2:0] mask, input logic [7:0] sw, input bit bounce);
    i_sw = sw;
    if (bounce) begin
      repeat (2) begin
        set_btns(mask);
        repeat ($urandom_range(1, DEB - 1)) tick();
        set_btns(3'b000);
        repeat ($urandom_range(1, DEB - 1)) tick();
      end
      check_all({tag, ".bounce"}, 1'b0);
    end
    set_btns(mask);
    expect_load(tag, mask, sw);
    repeat ($urandom_range(0, 5)) tick();
    check_all({tag, ".held"}, 1'b0);
    set_btns(3'b000);
    repeat (DEB + 4) tick();
    check_all({tag, ".rel"}, 1'b0);
  endtask

  task automatic do_reset(input string tag);
    i_rst = 1'b1;
    tick();
    model_reset();
    check_all(tag, 1'b0);
    i_rst = 1'b0;
  endtask

  initial begin
    model_reset();
    repeat (3) tick();
    check_all("reset", 1'b0);
    i_rst = 1'b0;

    do_press("seqA", 3'b001, 8'h05, 1'b0);
    do_press("seqB", 3'b010, 8'h03, 1'b0);
    do_press("seqOP", 3'b100, 8'h20, 1'b0);
    do_press("doneA", 3'b001, 8'hFA, 1'b0);

    do_reset("rst1");
    do_press("wrongB", 3'b010, 8'h09, 1'b0);
    do_press("bounceA", 3'b001, 8'h0C, 1'b1);
    do_press("loadB", 3'b010, 8'h07, 1'b0);
    do_reset("rstOP");

    do_press("simulAB", 3'b011, 8'h06, 1'b0);

    // Button held through reset yields exactly one press after release
    i_sw = 8'h3B;
    set_btns(3'b001);
    i_rst = 1'b1;
    repeat (3) tick();
    model_reset();
    check_all("heldrst.in", 1'b0);
    i_rst = 1'b0;
    expect_load("heldrst", 3'b001, 8'h3B);
    set_btns(3'b000);
    repeat (DEB + 4) tick();
    check_all("heldrst.rel", 1'b0);

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_reset("rnd.rst");
      end else begin
        do_press("rnd", 3'($urandom_range(1, 7)), 8'($urandom), $urandom_range(0, 3) == 0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

`default_nettype wire

// File: doc/operand_loader.md
OPERAND_LOADER -- requirements
Module: operand_loader

Interface
REQ-001 Parameter NB_DATA, default 4: operand width (datoA, datoB).
REQ-002 Parameter NB_OP, default 6: operation code width.
REQ-003 Parameter NB_SW, default 8: switch bank width; SHALL be >= max(NB_DATA, NB_OP).
REQ-004 Parameter DEB_CYCLES, default 500000: debounce stability length in clk cycles; >= 2.
REQ-005 Clock and reset: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  system clock; all state updates on rising edge.
REQ-007 i_rst  input  1  synchronous active-high reset.
REQ-008 i_sw  input  NB_SW  raw board switches carrying the value to load.
REQ-009 i_btn_a  input  1  raw push-button: load datoA.
REQ-010 i_btn_b  input  1  raw push-button: load datoB.
REQ-011 i_btn_op  input  1  raw push-button: load operation.
REQ-012 o_datoA  output  NB_DATA  registered operand A to ALU.
REQ-013 o_datoB  output  NB_DATA  registered operand B to ALU.
REQ-014 o_operation  output  NB_OP  registered operation code to ALU.
REQ-015 o_valid  output  1  one-cycle pulse: full operand set newly complete.
REQ-016 o_ready  output  1  level: all three fields loaded (state S_DONE).
REQ-017 o_state  output  2  current FSM state, for status LEDs.

Function
REQ-018 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-019 Debounce: per button, counter clears whenever synced input equals stable level; stable level SHALL toggle only after DEB_CYCLES consecutive cycles of the opposite level.
REQ-020 Press pulse: one-cycle pulse on stable 0->1; none on 1->0; a held button yields exactly one pulse.
REQ-021 Latency: raw rise held steady -> press pulse asserted 2+DEB_CYCLES cycles later; bounces shorter than DEB_CYCLES SHALL produce no pulse.
REQ-022 FSM states, encoding: S_A=00, S_B=01, S_OP=10, S_DONE=11; o_state equals current state.
REQ-023 S_A: press_a -> o_datoA <= i_sw[NB_DATA-1:0], next S_B; press_b/press_op ignored.
REQ-024 S_B: press_b -> o_datoB <= i_sw[NB_DATA-1:0], next S_OP; others ignored.
REQ-025 S_OP: press_op -> o_operation <= i_sw[NB_OP-1:0], next S_DONE; o_valid high the cycle after the pulse (first S_DONE cycle) only.
REQ-026 S_DONE: o_ready=1; press_a reloads o_datoA and goes to S_B; press_b/press_op ignored; o_datoB/o_operation hold until reloaded.
REQ-027 Simultaneous pulses: only the pulse matching the current state acts; others dropped, not queued.
REQ-028 Upper switch bits beyond the loaded width SHALL be ignored; no sign extension.
REQ-029 All outputs SHALL be registered; fields not being loaded hold their value.

Reset
REQ-030 During i_rst: state S_A, o_datoA=0, o_datoB=0, o_operation=0, o_valid=0, o_ready=0, synchronizers, stable levels and counters 0.
REQ-031 Reset mid-sequence SHALL abort and discard loaded fields; a button held through reset SHALL produce one pulse DEB_CYCLES+2 cycles after release of reset.

Structure
REQ-032 Shared package/include SHALL hold state encodings (S_A..S_DONE) and default widths NB_DATA, NB_OP.
REQ-033 Synchronizer, debounce and edge detect SHALL be one sub-module, btn_debounce, instantiated three times; FSM and operand registers in operand_loader.

Verification (DEB_CYCLES=4)
REQ-034 Reset, then i_sw=8'h05 press A, 8'h03 press B, 8'h20 press OP -> o_datoA=5, o_datoB=3, o_operation=6'h20, o_valid one cycle, o_ready=1, o_state=11.
REQ-035 Button bouncing 1-0-1-0 with 2-cycle segments then steady 1 -> single pulse 6 cycles after steady rise; no load from bounces.
REQ-036 In S_A press B with i_sw=8'h09 -> o_datoB stays 0, state stays 00.
REQ-037 In S_DONE press A with i_sw=8'hFA -> o_datoA=4'hA, state 01, o_ready=0, o_datoB/o_operation unchanged.
REQ-038 Assert i_rst in S_OP after loads -> next cycle all outputs 0, state 00.
REQ-039 Press A and B same cycle in S_A -> only datoA loads, state 01, datoB unchanged.
